// File: rtl/adsr_envelope_controller.sv
// ADSR envelope sequencer: turns attack/decay/sustain/release rates into a 31-bit gain for the ALUcontroller.
// Optional ADSR_RETRIGGER_EN: a note/octave change while the gate is held restarts ATTACK from the current level.
module adsr_envelope_controller #(
    parameter int TICK_DIV = 1042
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_in,
    input  logic [3:0]  note,
    input  logic [2:0]  octave,
    input  logic [30:0] amplitude,
    input  logic [30:0] attack,
    input  logic [30:0] decay,
    input  logic [30:0] sustain,
    input  logic [30:0] rel,
    input  logic        ext_tick,
    input  logic        ext_tick_sel,
    output logic [30:0] env,
    output logic        env_strobe,
    output logic [2:0]  state,
    output logic        busy
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_gate_q;
    logic [30:0]      r_env;
    logic [2:0]       r_state;
    logic             r_strobe;

    logic        w_rise;
    logic        w_fall;
    logic        w_start;
    logic        w_active;
    logic        w_tick;
    logic [30:0] w_sus;
    logic [31:0] w_sum;
    logic [31:0] w_dec;
    logic [31:0] w_rdec;
    logic [30:0] w_env_nxt;
    logic [2:0]  w_state_nxt;
    logic        w_strobe_nxt;

    assign w_active = (r_state == ST_ATTACK) || (r_state == ST_DECAY) || (r_state == ST_SUSTAIN);
    assign w_rise   = note_in & ~r_gate_q;
    assign w_fall   = ~note_in & r_gate_q;
    assign w_tick   = ext_tick_sel ? ext_tick : (r_div == DIV_LAST);
    assign w_sus    = (sustain < amplitude) ? sustain : amplitude;

`ifdef ADSR_RETRIGGER_EN
    logic [6:0] r_key_q;
    logic       w_key_chg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_q <= '0;
        end else begin
            r_key_q <= {octave, note};
        end
    end

    assign w_key_chg = note_in && w_active && ({octave, note} != r_key_q);
    assign w_start   = w_rise | w_key_chg;
`else
    logic w_unused_key;
    assign w_unused_key = ^{octave, note};
    assign w_start      = w_rise;
`endif

    // Gate edges take priority over the tick; sums and differences carry an extra bit so env saturates instead of wrapping.
    always_comb begin
        w_sum        = {1'b0, r_env} + {1'b0, attack};
        w_dec        = {1'b0, r_env} - {1'b0, decay};
        w_rdec       = {1'b0, r_env} - {1'b0, rel};
        w_env_nxt    = r_env;
        w_state_nxt  = r_state;
        w_strobe_nxt = 1'b0;
        if (w_start) begin
            w_state_nxt = ST_ATTACK;
        end else if (w_fall && w_active) begin
            w_state_nxt = ST_RELEASE;
        end else if (w_tick) begin
            w_strobe_nxt = (r_state != ST_IDLE);
            case (r_state)
                ST_ATTACK: begin
                    if ((attack == '0) || (r_env >= amplitude) || (w_sum >= {1'b0, amplitude})) begin
                        w_env_nxt   = amplitude;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_env_nxt = w_sum[30:0];
                    end
                end
                ST_DECAY: begin
                    if ((decay == '0) || w_dec[31] || (w_dec[30:0] <= w_sus)) begin
                        w_env_nxt   = w_sus;
                        w_state_nxt = ST_SUSTAIN;
                    end else begin
                        w_env_nxt = w_dec[30:0];
                    end
                end
                ST_SUSTAIN: begin
                    w_env_nxt = w_sus;
                end
                ST_RELEASE: begin
                    if ((rel == '0) || w_rdec[31] || (w_rdec[30:0] == '0)) begin
                        w_env_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_env_nxt = w_rdec[30:0];
                    end
                end
                default: begin
                    w_env_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // The tick divider free-runs in every state so tick phase never depends on note activity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div    <= '0;
            r_gate_q <= 1'b0;
            r_env    <= '0;
            r_state  <= ST_IDLE;
            r_strobe <= 1'b0;
        end else begin
            r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            r_gate_q <= note_in;
            r_env    <= w_env_nxt;
            r_state  <= w_state_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign env        = r_env;
    assign env_strobe = r_strobe;
    assign state      = r_state;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope_controller.sv
// Self-checking bench for adsr_envelope_controller: directed scenarios plus a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_adsr_envelope_controller;
    localparam int TDIV = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        note_in = 1'b0;
    logic [3:0]  note = 4'd3;
    logic [2:0]  octave = 3'd2;
    logic [30:0] amplitude = '0;
    logic [30:0] attack = '0;
    logic [30:0] decay = '0;
    logic [30:0] sustain = '0;
    logic [30:0] rel = '0;
    logic        ext_tick = 1'b0;
    logic        ext_tick_sel = 1'b1;
    logic [30:0] env;
    logic        env_strobe;
    logic [2:0]  state;
    logic        busy;

    int nChecks = 0;
    int nPass = 0;

    int     mState;
    longint mEnv;
    bit     mGate;

    adsr_envelope_controller #(.TICK_DIV(TDIV)) dut (
        .clk(clk), .reset(reset), .note_in(note_in), .note(note), .octave(octave),
        .amplitude(amplitude), .attack(attack), .decay(decay), .sustain(sustain), .rel(rel),
        .ext_tick(ext_tick), .ext_tick_sel(ext_tick_sel),
        .env(env), .env_strobe(env_strobe), .state(state), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseTick();
        ext_tick = 1'b1;
        cycle();
        ext_tick = 1'b0;
    endtask

    task automatic hardReset();
        note_in = 1'b0;
        ext_tick = 1'b0;
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic setParams(input int amp, input int att, input int dec, input int sus, input int rl);
        amplitude = 31'(amp);
        attack    = 31'(att);
        decay     = 31'(dec);
        sustain   = 31'(sus);
        rel       = 31'(rl);
    endtask

    // Behavioural reference: envelope level as a plain signed integer, phases numbered as on the state port.
    task automatic modelStep(output bit expStrobe);
        longint peak, susLvl, t;
        bit rise, fall;
        peak   = longint'(amplitude);
        susLvl = (longint'(sustain) < peak) ? longint'(sustain) : peak;
        rise   = note_in && !mGate;
        fall   = !note_in && mGate;
        mGate  = note_in;
        expStrobe = 1'b0;
        if (rise) begin
            mState = 1;
        end else if (fall && mState >= 1 && mState <= 3) begin
            mState = 4;
        end else if (ext_tick) begin
            expStrobe = (mState != 0);
            case (mState)
                1: begin
                    t = mEnv + longint'(attack);
                    if (attack == 0 || mEnv >= peak || t >= peak) begin mEnv = peak; mState = 2; end
                    else mEnv = t;
                end
                2: begin
                    t = mEnv - longint'(decay);
                    if (decay == 0 || t <= susLvl) begin mEnv = susLvl; mState = 3; end
                    else mEnv = t;
                end
                3: mEnv = susLvl;
                4: begin
                    t = mEnv - longint'(rel);
                    if (rel == 0 || t <= 0) begin mEnv = 0; mState = 0; end
                    else mEnv = t;
                end
                default: mEnv = 0;
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle();
        cycle();
        nChecks++; if (state !== 3'd0) $display("[TB] FAIL reset_state: got=%0d want=0", state); else nPass++;
        nChecks++; if (env !== 31'd0) $display("[TB] FAIL reset_env: got=%0d want=0", env); else nPass++;
        nChecks++; if (env_strobe !== 1'b0) $display("[TB] FAIL reset_strobe: got=%b want=0", env_strobe); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got=%b want=0", busy); else nPass++;
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_full_envelope();
        int expA[8] = '{300, 600, 900, 1000, 900, 800, 700, 600};
        int expR[3] = '{400, 200, 0};
        setParams(1000, 300, 100, 600, 200);
        note_in = 1'b1;
        cycle();
        nChecks++; if (state !== 3'd1 || busy !== 1'b1) $display("[TB] FAIL gate_latency: state=%0d busy=%b want=1/1", state, busy); else nPass++;
        for (int i = 0; i < 8; i++) begin
            pulseTick();
            nChecks++; if (env !== 31'(expA[i]) || env_strobe !== 1'b1) $display("[TB] FAIL full_ads_%0d: env=%0d strobe=%b want=%0d/1", i, env, env_strobe, expA[i]); else nPass++;
            if (i == 3) begin
                nChecks++; if (state !== 3'd2) $display("[TB] FAIL full_decay_state: got=%0d want=2", state); else nPass++;
            end
        end
        nChecks++; if (state !== 3'd3) $display("[TB] FAIL full_sustain_state: got=%0d want=3", state); else nPass++;
        note_in = 1'b0;
        cycle();
        nChecks++; if (state !== 3'd4 || env !== 31'd600) $display("[TB] FAIL full_fall: state=%0d env=%0d want=4/600", state, env); else nPass++;
        for (int i = 0; i < 3; i++) begin
            pulseTick();
            nChecks++; if (env !== 31'(expR[i]) || env_strobe !== 1'b1) $display("[TB] FAIL full_rel_%0d: env=%0d strobe=%b want=%0d/1", i, env, env_strobe, expR[i]); else nPass++;
        end
        nChecks++; if (state !== 3'd0 || busy !== 1'b0) $display("[TB] FAIL full_idle: state=%0d busy=%b want=0/0", state, busy); else nPass++;
        pulseTick();
        nChecks++; if (env_strobe !== 1'b0 || env !== 31'd0) $display("[TB] FAIL idle_tick: strobe=%b env=%0d want=0/0", env_strobe, env); else nPass++;
    endtask

    task automatic test_retrigger_release();
        setParams(1000, 300, 100, 600, 200);
        note_in = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) pulseTick();
        note_in = 1'b0;
        cycle();
        pulseTick();
        nChecks++; if (env !== 31'd400 || state !== 3'd4) $display("[TB] FAIL retrig_pre: env=%0d state=%0d want=400/4", env, state); else nPass++;
        note_in = 1'b1;
        cycle();
        nChecks++; if (state !== 3'd1 || env !== 31'd400) $display("[TB] FAIL retrig_attack: state=%0d env=%0d want=1/400", state, env); else nPass++;
        pulseTick();
        nChecks++; if (env !== 31'd700) $display("[TB] FAIL retrig_tick: env=%0d want=700", env); else nPass++;
        note_in = 1'b0;
        cycle();
        note_in = 1'b1;
        cycle();
        note_in = 1'b0;
        cycle();
        nChecks++; if (state !== 3'd4 || env !== 31'd700) $display("[TB] FAIL rise_fall: state=%0d env=%0d want=4/700", state, env); else nPass++;
        hardReset();
    endtask

    task automatic test_instant_rates();
        setParams(1000, 0, 0, 500, 0);
        note_in = 1'b1;
        cycle();
        pulseTick();
        nChecks++; if (env !== 31'd1000 || state !== 3'd2) $display("[TB] FAIL instant_t1: env=%0d state=%0d want=1000/2", env, state); else nPass++;
        pulseTick();
        nChecks++; if (env !== 31'd500 || state !== 3'd3) $display("[TB] FAIL instant_t2: env=%0d state=%0d want=500/3", env, state); else nPass++;
        note_in = 1'b0;
        cycle();
        pulseTick();
        nChecks++; if (env !== 31'd0 || state !== 3'd0 || env_strobe !== 1'b1) $display("[TB] FAIL instant_rel: env=%0d state=%0d strobe=%b want=0/0/1", env, state, env_strobe); else nPass++;
        hardReset();
    endtask

    task automatic test_saturation();
        amplitude = 31'h7FFFFFFF;
        attack    = 31'h70000000;
        decay     = '0;
        sustain   = 31'd5000;
        rel       = '0;
        note_in = 1'b1;
        cycle();
        pulseTick();
        nChecks++; if (env !== 31'h70000000) $display("[TB] FAIL sat_t1: env=%h want=70000000", env); else nPass++;
        pulseTick();
        nChecks++; if (env !== 31'h7FFFFFFF || state !== 3'd2) $display("[TB] FAIL sat_t2: env=%h state=%0d want=7fffffff/2", env, state); else nPass++;
        amplitude = 31'd1000;
        pulseTick();
        nChecks++; if (env !== 31'd1000 || state !== 3'd3) $display("[TB] FAIL sat_sus_clamp: env=%0d state=%0d want=1000/3", env, state); else nPass++;
        hardReset();
    endtask

    task automatic test_collision();
        setParams(1000, 0, 0, 600, 100);
        note_in = 1'b1;
        cycle();
        pulseTick();
        pulseTick();
        note_in = 1'b0;
        pulseTick();
        nChecks++; if (state !== 3'd4 || env !== 31'd600 || env_strobe !== 1'b0) $display("[TB] FAIL collision: state=%0d env=%0d strobe=%b want=4/600/0", state, env, env_strobe); else nPass++;
        hardReset();
    endtask

    task automatic test_reset_mid_attack();
        setParams(1000, 100, 50, 500, 50);
        note_in = 1'b1;
        cycle();
        pulseTick();
        pulseTick();
        #2 reset = 1'b0;
        #1;
        nChecks++; if (env !== 31'd0 || state !== 3'd0 || busy !== 1'b0) $display("[TB] FAIL reset_mid: env=%0d state=%0d busy=%b want=0/0/0", env, state, busy); else nPass++;
        note_in = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_note_change();
        logic [2:0] wantState;
`ifdef ADSR_RETRIGGER_EN
        wantState = 3'd1;
`else
        wantState = 3'd3;
`endif
        setParams(1000, 0, 0, 600, 100);
        note = 4'd3;
        cycle();
        note_in = 1'b1;
        cycle();
        pulseTick();
        pulseTick();
        note = 4'd5;
        cycle();
        nChecks++; if (state !== wantState || env !== 31'd600) $display("[TB] FAIL note_change: state=%0d env=%0d want=%0d/600", state, env, wantState); else nPass++;
        note = 4'd3;
        hardReset();
    endtask

    task automatic test_divider();
        int strobes, gapBad, lastAt;
        logic [30:0] env0;
        setParams(1000, 1, 1, 500, 1);
        note_in = 1'b1;
        cycle();
        ext_tick_sel = 1'b0;
        env0 = env;
        strobes = 0;
        gapBad = 0;
        lastAt = -1;
        for (int i = 0; i < 10 * TDIV; i++) begin
            cycle();
            if (env_strobe) begin
                if (lastAt >= 0 && i - lastAt != TDIV) gapBad++;
                lastAt = i;
                strobes++;
            end
        end
        nChecks++; if (strobes != 10) $display("[TB] FAIL div_count: got=%0d want=10", strobes); else nPass++;
        nChecks++; if (gapBad != 0) $display("[TB] FAIL div_spacing: bad_gaps=%0d want=0", gapBad); else nPass++;
        nChecks++; if (env - env0 !== 31'd10) $display("[TB] FAIL div_env: delta=%0d want=10", env - env0); else nPass++;
        ext_tick_sel = 1'b1;
        hardReset();
    endtask

    task automatic test_random();
        bit expStrobe;
        int errs;
        hardReset();
        mState = 0;
        mEnv = 0;
        mGate = 1'b0;
        errs = 0;
        setParams(1000, 200, 100, 500, 150);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    amplitude = 31'h7FFFFF00 + 31'($urandom_range(0, 255));
                    attack    = 31'($urandom);
                    sustain   = 31'($urandom);
                end else begin
                    amplitude = 31'($urandom_range(0, 3000));
                    attack    = ($urandom_range(0, 4) == 0) ? '0 : 31'($urandom_range(1, 700));
                    sustain   = 31'($urandom_range(0, 4000));
                end
                decay = ($urandom_range(0, 4) == 0) ? '0 : 31'($urandom_range(1, 700));
                rel   = ($urandom_range(0, 4) == 0) ? '0 : 31'($urandom_range(1, 700));
            end
            if ($urandom_range(0, 29) == 0) note_in = ~note_in;
            ext_tick = ($urandom_range(0, 2) == 0);
            modelStep(expStrobe);
            cycle();
            if (errs < 10) begin
                nChecks++;
                if (env !== 31'(mEnv) || state !== 3'(mState) || env_strobe !== expStrobe || busy !== (mState != 0)) begin
                    $display("[TB] FAIL random_%0d: env=%0d state=%0d strobe=%b busy=%b want=%0d/%0d/%b/%b",
                             i, env, state, env_strobe, busy, mEnv, mState, expStrobe, mState != 0);
                    errs++;
                end else nPass++;
            end
        end
        ext_tick = 1'b0;
        hardReset();
    endtask

    initial begin
        test_reset();
        test_full_envelope();
        test_retrigger_release();
        test_instant_rates();
        test_saturation();
        test_collision();
        test_reset_mid_attack();
        test_note_change();
        test_divider();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
